// File: rtl/dcache_responder.sv
// dcache_responder: blocking direct-mapped write-back cache between
// the LSU dmem port and a line-wide backing memory port.
module dcache_responder #(
    parameter int NUM_SETS = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  ufp_addr,
    input  logic [3:0]   ufp_rmask,
    input  logic [3:0]   ufp_wmask,
    input  logic [31:0]  ufp_wdata,
    output logic [31:0]  ufp_rdata,
    output logic         ufp_resp,
    output logic [31:0]  dfp_addr,
    output logic         dfp_read,
    output logic         dfp_write,
    output logic [255:0] dfp_wdata,
    input  logic [255:0] dfp_rdata,
    input  logic         dfp_resp
);

    localparam int IDX = $clog2(NUM_SETS);
    localparam int TAG = 27 - IDX;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TAG  = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;
    localparam logic [1:0] S_FILL = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_n;

    // word address of the request in flight
    logic [29:0] req_addr;
    logic [3:0]  req_wmask;
    logic [31:0] req_wdata;

    logic [255:0]        data_arr [NUM_SETS];
    logic [TAG-1:0]      tag_arr  [NUM_SETS];
    logic [NUM_SETS-1:0] valid;
    logic [NUM_SETS-1:0] dirty;

    logic [2:0]     req_word;
    logic [IDX-1:0] req_idx;
    logic [TAG-1:0] req_tag;
    logic [255:0]   line;
    logic [TAG-1:0] old_tag;
    logic [255:0]   merged;
    logic [7:0]     bsel;
    logic [31:0]    line_word;

    logic req_any;
    logic accept;
    logic is_write;
    logic hit;
    logic write_hit;
    logic fill_done;
    logic unused_addr;

    assign unused_addr = ^ufp_addr[1:0];

    assign req_word = req_addr[2:0];
    assign req_idx  = req_addr[3 +: IDX];
    assign req_tag  = req_addr[29 -: TAG];

    assign line     = data_arr[req_idx];
    assign old_tag  = tag_arr[req_idx];
    assign is_write = |req_wmask;
    assign hit      = valid[req_idx] && (old_tag == req_tag);

    assign line_word = line[{req_word, 5'd0} +: 32];

    assign req_any   = |(ufp_rmask | ufp_wmask);
    assign accept    = (state == S_IDLE) && req_any;
    assign write_hit = (state == S_TAG) && hit && is_write;
    assign fill_done = (state == S_FILL) && dfp_resp;

    always_comb begin
        merged = line;
        bsel   = '0;
        for (int b = 0; b < 4; b++) begin
            bsel = {req_word, 2'(b), 3'd0};
            if (req_wmask[b]) begin
                merged[bsel +: 8] = req_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (req_any) begin
                    state_n = S_TAG;
                end
            end
            S_TAG: begin
                if (hit) begin
                    state_n = S_IDLE;
                end else if (valid[req_idx] && dirty[req_idx]) begin
                    state_n = S_WB;
                end else begin
                    state_n = S_FILL;
                end
            end
            S_WB: begin
                if (dfp_resp) begin
                    state_n = S_FILL;
                end
            end
            S_FILL: begin
                if (dfp_resp) begin
                    state_n = S_TAG;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // strobes and their data buses are forced low during reset
    always_comb begin
        ufp_resp  = 1'b0;
        ufp_rdata = '0;
        dfp_read  = 1'b0;
        dfp_write = 1'b0;
        dfp_addr  = '0;
        dfp_wdata = '0;
        if (rst) begin
            unique case (1'b1)
                (state == S_TAG): begin
                    ufp_resp = hit;
                    if (hit && !is_write) begin
                        ufp_rdata = line_word;
                    end
                end
                (state == S_WB): begin
                    dfp_write = 1'b1;
                    dfp_addr  = {old_tag, req_idx, 5'd0};
                    dfp_wdata = line;
                end
                (state == S_FILL): begin
                    dfp_read = 1'b1;
                    dfp_addr = {req_tag, req_idx, 5'd0};
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            valid     <= '0;
            dirty     <= '0;
            req_addr  <= '0;
            req_wmask <= '0;
            req_wdata <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                req_addr  <= ufp_addr[31:2];
                req_wmask <= ufp_wmask;
                req_wdata <= ufp_wdata;
            end
            if (fill_done) begin
                valid[req_idx] <= 1'b1;
                dirty[req_idx] <= 1'b0;
            end else if (write_hit) begin
                dirty[req_idx] <= 1'b1;
            end
        end
    end

    // line storage is not cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            if (fill_done) begin
                data_arr[req_idx] <= dfp_rdata;
                tag_arr[req_idx]  <= req_tag;
            end else if (write_hit) begin
                data_arr[req_idx] <= merged;
            end
        end
    end

endmodule
